wb_write_stage: RTL and testbench

WB_WRITE_STAGE -- requirements
Module: wb_write_stage

---
 rtl/wb_write_stage_pkg.sv | 16 +
 rtl/dec5_32_en.sv | 14 +
 rtl/wb_write_stage.sv | 94 +++++++++
 tb/tb_wb_write_stage.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_stage_pkg.sv
// Shared definitions for the write-back stage: register addressing, the zero-register
// index and the layout of one pending {rd, data} write.
package wb_write_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] XZR = 5'd31;

  // Storage width of one pending write; the stage's DATA_W must not exceed it.
  localparam int ENTRY_DATA_W = 64;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [ENTRY_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/dec5_32_en.sv
// 5-to-32 one-hot decoder with enable; all outputs low while en is low.
module dec5_32_en (
  input  logic [4:0]  code,
  input  logic        en,
  output logic [31:0] out
);

  always_comb begin
    // NOTE: default assignment first so no path leaves out unassigned (no latch).
    out = '0;
    if (en) out[code] = 1'b1;
  end

endmodule

// File: rtl/wb_write_stage.sv
// Register-file write-back stage: 2-entry FIFO of pending writes drained into a one-hot write port.
// Optional forwarding of the youngest pending write is built when WB_FWD_EN is defined.
module wb_write_stage
  import wb_write_stage_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_regwrite,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  port_busy,
  output logic [NUM_REGS-1:0]   wr_en,
  output logic [DATA_W-1:0]     wr_data
`ifdef WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  wb_entry_t   fifo [2];
  wb_entry_t   head;
  wb_entry_t   new_entry;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        ready_q;
  logic        non_empty;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] dec_out;

  // Readiness comes only from registered state; ready_q keeps it low until the first edge out of reset.
  assign in_ready  = ready_q && (count != 2'd2);
  assign non_empty = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && in_regwrite && (in_rd != XZR);
  assign pop       = non_empty && !port_busy;
  assign head      = fifo[rd_ptr];

  assign new_entry.rd   = in_rd;
  assign new_entry.data = ENTRY_DATA_W'(in_data);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= new_entry;
  end

  dec5_32_en u_dec (
    .code (head.rd),
    .en   (pop),
    .out  (dec_out)
  );

  assign wr_en   = NUM_REGS'(dec_out);
  assign wr_data = non_empty ? DATA_W'(head.data) : '0;

`ifdef WB_FWD_EN
  wb_entry_t youngest;

  // The most recent push sits one slot behind the write pointer.
  assign youngest  = fifo[~wr_ptr];
  assign fwd_valid = non_empty;
  assign fwd_rd    = non_empty ? youngest.rd : '0;
  assign fwd_data  = non_empty ? DATA_W'(youngest.data) : '0;
`endif

endmodule

// File: tb/tb_wb_write_stage.sv
// Self-checking bench for wb_write_stage: directed scenarios plus randomized traffic
// compared against a queue-based model of pending register writes.
module tb_wb_write_stage;

  localparam int DATA_W   = 64;
  localparam int NUM_REGS = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_regwrite = 1'b0;
  logic [4:0]        in_rd = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              port_busy = 1'b0;
  logic              in_ready;
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0] wr_data;
`ifdef WB_FWD_EN
  logic              fwd_valid;
  logic [4:0]        fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } req_t;

  // Model: pending writes in arrival order, and whether an edge has passed since reset.
  req_t q[$];
  bit   m_ready = 1'b0;

  logic                exp_ready;
  logic [NUM_REGS-1:0] exp_wr_en;
  logic [DATA_W-1:0]   exp_wr_data;

  always #5 clk = ~clk;

  wb_write_stage #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_regwrite (in_regwrite),
    .in_rd       (in_rd),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .port_busy   (port_busy),
    .wr_en       (wr_en),
    .wr_data     (wr_data)
`ifdef WB_FWD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data)
`endif
  );

  // Expected outputs for the current model state and inputs.
  function automatic void model_outputs();
    exp_ready   = m_ready && (q.size() < 2);
    exp_wr_en   = '0;
    exp_wr_data = '0;
    if (q.size() > 0) begin
      exp_wr_data = q[0].data;
      if (!port_busy && reset) exp_wr_en = NUM_REGS'(1) << q[0].rd;
    end
  endfunction

  // Called just after a falling edge: apply inputs, let them settle, compute expectations.
  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [DATA_W-1:0] d, input logic busy);
    in_valid    = v;
    in_regwrite = rw;
    in_rd       = rd;
    in_data     = d;
    port_busy   = busy;
    #1;
    model_outputs();
  endtask

  // Advance one clock and apply the write-back rules to the model.
  task automatic tick();
    bit acc;
    bit pop;
    acc = in_valid && m_ready && (q.size() < 2);
    pop = (q.size() > 0) && !port_busy;
    @(posedge clk);
    if (reset) begin
      if (pop) void'(q.pop_front());
      if (acc && in_regwrite && in_rd != 5'd31) q.push_back('{rd: in_rd, data: in_data});
      m_ready = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd0, '0, 1'b0);
      tick();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b0 || wr_en !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b wr_en=%h wr_data=%h, expected 0/0/0", in_ready, wr_en, wr_data);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_before_edge: ready=%b, expected 0", in_ready);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0);
    checks++;
    if (in_ready !== 1'b1 || in_ready !== exp_ready) begin
      errors++;
      $display("FAIL reset_first_edge: ready=%b, expected 1", in_ready);
    end
  endtask

  task automatic test_single_write();
    drive(1'b1, 1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0);
    checks++;
    if (in_ready !== exp_ready || wr_en !== exp_wr_en || wr_data !== exp_wr_data) begin
      errors++;
      $display("FAIL single_accept: ready=%b wr_en=%h wr_data=%h, expected %b/%h/%h",
               in_ready, wr_en, wr_data, exp_ready, exp_wr_en, exp_wr_data);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0);
    checks++;
    if (wr_en !== 32'h0000_0020 || wr_data !== 64'hDEAD_BEEF || wr_en !== exp_wr_en) begin
      errors++;
      $display("FAIL single_write: wr_en=%h wr_data=%h, expected 00000020/deadbeef", wr_en, wr_data);
    end
    tick();
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0);
    checks++;
    if (wr_en !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL single_one_cycle: wr_en=%h wr_data=%h, expected 0/0", wr_en, wr_data);
    end
  endtask

  task automatic test_no_push();
    logic       rw_tab [3] = '{1'b1, 1'b0, 1'b0};
    logic [4:0] rd_tab [3] = '{5'd31, 5'd7, 5'd0};
    logic       v_tab  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(v_tab[i], rw_tab[i], rd_tab[i], {$urandom, $urandom}, 1'b0);
      checks++;
      if (in_ready !== 1'b1 || wr_en !== '0 || wr_data !== '0 || wr_data !== exp_wr_data) begin
        errors++;
        $display("FAIL no_push[%0d]: ready=%b wr_en=%h wr_data=%h, expected 1/0/0", i, in_ready, wr_en, wr_data);
      end
      tick();
    end
  endtask

  task automatic test_full_backpressure();
    // Two accepts while the port is busy, then rd=3 is refused, then the port frees up.
    logic       v_tab    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] rd_tab   [7] = '{5'd1, 5'd2, 5'd3, 5'd3, 5'd0, 5'd0, 5'd0};
    logic       busy_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [NUM_REGS-1:0] want_en [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h2, 32'h4, 32'h0};
    logic       want_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(v_tab[i], 1'b1, rd_tab[i], {32'hA5A5_0000, 27'd0, rd_tab[i]}, busy_tab[i]);
      checks++;
      if (in_ready !== want_rdy[i] || wr_en !== want_en[i] ||
          in_ready !== exp_ready || wr_en !== exp_wr_en || wr_data !== exp_wr_data) begin
        errors++;
        $display("FAIL backpressure[%0d]: ready=%b wr_en=%h wr_data=%h, expected %b/%h/%h",
                 i, in_ready, wr_en, wr_data, want_rdy[i], want_en[i], exp_wr_data);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    // Occupancy 1, then push rd=4 while rd=10 pops; rd=4 follows, then the FIFO is empty.
    logic       v_tab    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [4:0] rd_tab   [4] = '{5'd10, 5'd4, 5'd0, 5'd0};
    logic       busy_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [NUM_REGS-1:0] want_en [4] = '{32'h0, 32'h400, 32'h10, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(v_tab[i], 1'b1, rd_tab[i], {$urandom, $urandom}, busy_tab[i]);
      checks++;
      if (wr_en !== want_en[i] || in_ready !== exp_ready || wr_en !== exp_wr_en || wr_data !== exp_wr_data) begin
        errors++;
        $display("FAIL back_to_back[%0d]: ready=%b wr_en=%h wr_data=%h, expected %b/%h/%h",
                 i, in_ready, wr_en, wr_data, exp_ready, want_en[i], exp_wr_data);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 5'd12, 64'h1111, 1'b1);
    tick();
    drive(1'b1, 1'b1, 5'd13, 64'h2222, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd0, '0, 1'b1);
    reset = 1'b0;
    q.delete();
    m_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || wr_en !== '0 || wr_data !== '0) begin
      errors++;
      $display("FAIL reset_mid_immediate: ready=%b wr_en=%h wr_data=%h, expected 0/0/0", in_ready, wr_en, wr_data);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 5'd0, '0, 1'b0);
      checks++;
      if (wr_en !== '0 || wr_data !== '0 || in_ready !== exp_ready) begin
        errors++;
        $display("FAIL reset_mid_stale[%0d]: ready=%b wr_en=%h wr_data=%h, expected %b/0/0",
                 i, in_ready, wr_en, wr_data, exp_ready);
      end
      tick();
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_forward();
    drive(1'b1, 1'b1, 5'd9, 64'h55, 1'b1);
    tick();
    drive(1'b0, 1'b0, 5'd0, '0, 1'b1);
    checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd9 || fwd_data !== 64'h55 || fwd_rd !== q[$].rd) begin
      errors++;
      $display("FAIL forward: valid=%b rd=%0d data=%h, expected 1/9/55", fwd_valid, fwd_rd, fwd_data);
    end
    drain();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom),
            {$urandom, $urandom}, $urandom_range(0, 2) == 0);
      checks++;
      if (in_ready !== exp_ready || wr_en !== exp_wr_en || wr_data !== exp_wr_data ||
          $countones(wr_en) > 1 || wr_en[31] !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d]: ready=%b wr_en=%h wr_data=%h, expected %b/%h/%h",
                 i, in_ready, wr_en, wr_data, exp_ready, exp_wr_en, exp_wr_data);
      end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_write();
    drain();
    test_no_push();
    drain();
    test_full_backpressure();
    drain();
    test_back_to_back();
    drain();
    test_reset_mid();
    drain();
`ifdef WB_FWD_EN
    test_forward();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
